// File: rtl/axi_line_rd_slave_if.sv
// AXI3 read-address / read-data channel bundle for axi_line_rd_slave.
// The master modport drives AR and rready; the slave modport drives arready and R.
interface axi_line_rd_slave_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_line_rd_slave.sv
// AXI3 read-only burst responder backed by a backdoor-loaded word memory.
// Define AXI_SLV_BEAT_GAP_EN to insert GAP idle cycles between beats of a burst.
module axi_line_rd_slave #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2,
    parameter int QDEPTH  = 2,
    parameter int GAP     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    axi_line_rd_slave_if.slave    axi,
    input  logic                  mem_we,
    input  logic [ADDR_W-1:0]     mem_waddr,
    input  logic [31:0]           mem_wdata
);
    localparam int QW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);
    localparam int LW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
`ifdef AXI_SLV_BEAT_GAP_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_BEAT = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    logic [31:0]       r_mem [2**ADDR_W];

    logic [3:0]        r_q_id    [QDEPTH];
    logic [ADDR_W-1:0] r_q_idx   [QDEPTH];
    logic [3:0]        r_q_len   [QDEPTH];
    logic [1:0]        r_q_burst [QDEPTH];
    logic              r_q_err   [QDEPTH];
    logic [QW-1:0]     r_wptr;
    logic [QW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;

    logic [1:0]        r_state;
    logic [LW-1:0]     r_lat;
    logic [GW-1:0]     r_gcnt;
    logic [ADDR_W-1:0] r_idx;
    logic [3:0]        r_beat;
    logic [3:0]        r_len;
    logic [1:0]        r_burst;
    logic              r_err;

    logic [3:0]        r_rid;
    logic [31:0]       r_rdata;
    logic [1:0]        r_rresp;
    logic              r_rlast;
    logic              r_rvalid;

    logic              w_arready;
    logic              w_push;
    logic              w_pop;
    logic [ADDR_W-1:0] w_ar_idx;
    logic              w_ar_err;
    logic              w_unused_addr;

    logic [ADDR_W-1:0] w_src_idx;
    logic [3:0]        w_src_beat;
    logic [3:0]        w_src_len;
    logic [1:0]        w_src_burst;
    logic              w_src_err;
    logic [31:0]       w_ld_data;
    logic [1:0]        w_ld_resp;
    logic              w_ld_last;
    logic [ADDR_W-1:0] w_nxt_idx;
    logic [3:0]        w_nxt_beat;

    function automatic logic [QW-1:0] f_inc(input logic [QW-1:0] p);
        return (p == QW'(QDEPTH - 1)) ? '0 : p + QW'(1);
    endfunction

    assign w_arready     = !rst && (r_count < CW'(QDEPTH));
    assign w_push        = axi.arvalid && w_arready;
    assign w_pop         = (r_state == S_IDLE) && (r_count != '0);
    assign w_ar_idx      = axi.araddr[ADDR_W+1:2];
    assign w_ar_err      = (axi.arsize != 3'b010) || axi.arburst[1];
    assign w_unused_addr = ^{axi.araddr[31:ADDR_W+2], axi.araddr[1:0]};

    assign axi.arready = w_arready;
    assign axi.rid     = r_rid;
    assign axi.rdata   = r_rdata;
    assign axi.rresp   = r_rresp;
    assign axi.rlast   = r_rlast;
    assign axi.rvalid  = r_rvalid;

    // In IDLE a beat can only be loaded straight from the queue head (LATENCY==1).
    always_comb begin
        w_src_idx   = r_idx;
        w_src_beat  = r_beat;
        w_src_len   = r_len;
        w_src_burst = r_burst;
        w_src_err   = r_err;
        if (r_state == S_IDLE) begin
            w_src_idx   = r_q_idx[r_rptr];
            w_src_beat  = '0;
            w_src_len   = r_q_len[r_rptr];
            w_src_burst = r_q_burst[r_rptr];
            w_src_err   = r_q_err[r_rptr];
        end
        w_ld_data  = w_src_err ? '0 : r_mem[w_src_idx];
        w_ld_resp  = w_src_err ? 2'b10 : 2'b00;
        w_ld_last  = (w_src_beat == w_src_len);
        w_nxt_idx  = (w_src_burst == 2'b00) ? w_src_idx : w_src_idx + ADDR_W'(1);
        w_nxt_beat = w_src_beat + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            r_mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_id[r_wptr]    <= axi.arid;
            r_q_idx[r_wptr]   <= w_ar_idx;
            r_q_len[r_wptr]   <= axi.arlen;
            r_q_burst[r_wptr] <= axi.arburst;
            r_q_err[r_wptr]   <= w_ar_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= f_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= f_inc(r_rptr);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_lat    <= '0;
            r_gcnt   <= '0;
            r_idx    <= '0;
            r_beat   <= '0;
            r_len    <= '0;
            r_burst  <= '0;
            r_err    <= 1'b0;
            r_rid    <= '0;
            r_rdata  <= '0;
            r_rresp  <= '0;
            r_rlast  <= 1'b0;
            r_rvalid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_rid   <= r_q_id[r_rptr];
                        r_len   <= r_q_len[r_rptr];
                        r_burst <= r_q_burst[r_rptr];
                        r_err   <= r_q_err[r_rptr];
                        if (LATENCY == 1) begin
                            r_rdata  <= w_ld_data;
                            r_rresp  <= w_ld_resp;
                            r_rlast  <= w_ld_last;
                            r_rvalid <= 1'b1;
                            r_idx    <= w_nxt_idx;
                            r_beat   <= w_nxt_beat;
                            r_state  <= S_BEAT;
                        end else begin
                            r_idx   <= r_q_idx[r_rptr];
                            r_beat  <= '0;
                            r_lat   <= LW'(LATENCY > 1 ? LATENCY - 2 : 0);
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_lat == '0) begin
                        r_rdata  <= w_ld_data;
                        r_rresp  <= w_ld_resp;
                        r_rlast  <= w_ld_last;
                        r_rvalid <= 1'b1;
                        r_idx    <= w_nxt_idx;
                        r_beat   <= w_nxt_beat;
                        r_state  <= S_BEAT;
                    end else begin
                        r_lat <= r_lat - LW'(1);
                    end
                end
                S_BEAT: begin
                    if (r_rvalid && axi.rready) begin
                        if (r_rlast) begin
                            r_rvalid <= 1'b0;
                            r_rlast  <= 1'b0;
                            r_state  <= S_IDLE;
                        end else if (GAP_EN) begin
                            r_rvalid <= 1'b0;
                            r_gcnt   <= GW'(GAP - 1);
                            r_state  <= S_GAP;
                        end else begin
                            r_rdata <= w_ld_data;
                            r_rresp <= w_ld_resp;
                            r_rlast <= w_ld_last;
                            r_idx   <= w_nxt_idx;
                            r_beat  <= w_nxt_beat;
                        end
                    end
                end
                default: begin
                    if (r_gcnt == '0) begin
                        r_rdata  <= w_ld_data;
                        r_rresp  <= w_ld_resp;
                        r_rlast  <= w_ld_last;
                        r_rvalid <= 1'b1;
                        r_idx    <= w_nxt_idx;
                        r_beat   <= w_nxt_beat;
                        r_state  <= S_BEAT;
                    end else begin
                        r_gcnt <= r_gcnt - GW'(1);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_axi_line_rd_slave.sv
// Directed bench for axi_line_rd_slave: inputs driven and outputs sampled on the falling edge.
// Beat spacing follows AXI_SLV_BEAT_GAP_EN so the same vectors cover both builds.
module tb_axi_line_rd_slave;
    localparam int ADDR_W  = 10;
    localparam int LATENCY = 2;
    localparam int QDEPTH  = 2;
    localparam int GAP     = 1;
`ifdef AXI_SLV_BEAT_GAP_EN
    localparam int G = GAP;
`else
    localparam int G = 0;
`endif
    localparam int ST = 1 + G;

    logic clk = 1'b0;
    logic rst;
    logic mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0] mem_wdata;

    always #5 clk = ~clk;

    axi_line_rd_slave_if bus();

    axi_line_rd_slave #(
        .ADDR_W(ADDR_W), .LATENCY(LATENCY), .QDEPTH(QDEPTH), .GAP(GAP)
    ) dut (
        .clk(clk), .rst(rst), .axi(bus),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] b_data [16];
    logic [3:0]  b_id   [16];
    logic [1:0]  b_resp [16];
    logic        b_last [16];
    int          b_cyc  [16];
    int          nb;

    task automatic bd_write(input int idx, input logic [31:0] d);
        mem_we = 1'b1;
        mem_waddr = ADDR_W'(idx);
        mem_wdata = d;
        @(negedge clk);
        mem_we = 1'b0;
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst, output int waited);
        bus.arid = id;
        bus.araddr = addr;
        bus.arlen = len;
        bus.arsize = size;
        bus.arburst = burst;
        bus.arvalid = 1'b1;
        waited = 0;
        while (!bus.arready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        @(negedge clk);
        bus.arvalid = 1'b0;
    endtask

    // Records R handshakes; cycle 0 is the falling edge at which it is called.
    task automatic collect(input int want, input int maxcyc);
        nb = 0;
        for (int c = 0; c < maxcyc && nb < want; c++) begin
            if (bus.rvalid && bus.rready) begin
                b_data[nb] = bus.rdata;
                b_id[nb]   = bus.rid;
                b_resp[nb] = bus.rresp;
                b_last[nb] = bus.rlast;
                b_cyc[nb]  = c;
                nb++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        n_cmp++;
        if ({bus.arready, bus.rvalid, bus.rlast, bus.rid, bus.rdata, bus.rresp} !== 40'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {bus.arready, bus.rvalid, bus.rlast, bus.rid, bus.rdata, bus.rresp});
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus.arready, bus.rvalid} !== 2'b10) begin
            n_bad++;
            $display("FAIL reset_release: got arready,rvalid=%b expected 10", {bus.arready, bus.rvalid});
        end
    endtask

    task automatic test_incr_burst;
        int w;
        send_ar(4'd3, 32'h0, 4'd7, 3'b010, 2'b01, w);
        n_cmp++;
        if (w !== 0) begin n_bad++; $display("FAIL incr_ar_wait: got %0d expected 0", w); end
        collect(8, 60);
        n_cmp++;
        if (nb !== 8) begin n_bad++; $display("FAIL incr_nbeats: got %0d expected 8", nb); end
        for (int k = 0; k < nb; k++) begin
            n_cmp++;
            if (b_data[k] !== 32'h1000_0000 + 32'(k)) begin
                n_bad++;
                $display("FAIL incr_data[%0d]: got %h expected %h", k, b_data[k], 32'h1000_0000 + 32'(k));
            end
            n_cmp++;
            if ({b_id[k], b_resp[k], b_last[k]} !== {4'd3, 2'b00, k == 7}) begin
                n_bad++;
                $display("FAIL incr_ctl[%0d]: got id,resp,last=%h,%b,%b expected 3,00,%b",
                         k, b_id[k], b_resp[k], b_last[k], k == 7);
            end
            n_cmp++;
            if (b_cyc[k] !== 2 + k * ST) begin
                n_bad++;
                $display("FAIL incr_cycle[%0d]: got %0d expected %0d", k, b_cyc[k], 2 + k * ST);
            end
        end
        n_cmp++;
        if (bus.rvalid !== 1'b0) begin n_bad++; $display("FAIL incr_after_last: got rvalid=%b expected 0", bus.rvalid); end
    endtask

    task automatic test_back_to_back;
        int w1, w2, w3, w4;
        logic [31:0] ed [11];
        logic [3:0]  ei [11];
        for (int k = 0; k < 8; k++) begin ed[k] = 32'h1000_0008 + 32'(k); ei[k] = 4'd1; end
        ed[8] = 32'h1000_0000; ei[8] = 4'd2;
        ed[9] = 32'h1000_0001; ei[9] = 4'd5;
        ed[10] = 32'h1000_0003; ei[10] = 4'd6;
        send_ar(4'd1, 32'h20, 4'd7, 3'b010, 2'b01, w1);
        send_ar(4'd2, 32'h0, 4'd0, 3'b010, 2'b01, w2);
        send_ar(4'd5, 32'h4, 4'd0, 3'b010, 2'b01, w3);
        n_cmp++;
        if ({w1, w2, w3} !== 96'h0) begin
            n_bad++;
            $display("FAIL b2b_no_stall: got waits %0d,%0d,%0d expected 0,0,0", w1, w2, w3);
        end
        fork
            send_ar(4'd6, 32'hC, 4'd0, 3'b010, 2'b01, w4);
            collect(11, 120);
        join
        n_cmp++;
        if (w4 !== 2 + 7 * ST) begin n_bad++; $display("FAIL b2b_full_stall: got %0d expected %0d", w4, 2 + 7 * ST); end
        n_cmp++;
        if (nb !== 11) begin n_bad++; $display("FAIL b2b_nbeats: got %0d expected 11", nb); end
        for (int k = 0; k < nb; k++) begin
            n_cmp++;
            if ({b_id[k], b_data[k], b_last[k]} !== {ei[k], ed[k], (k >= 7)}) begin
                n_bad++;
                $display("FAIL b2b_beat[%0d]: got id=%h data=%h last=%b expected id=%h data=%h last=%b",
                         k, b_id[k], b_data[k], b_last[k], ei[k], ed[k], k >= 7);
            end
        end
        n_cmp++;
        if (b_cyc[8] !== 7 * ST + 3) begin n_bad++; $display("FAIL b2b_next_pop: got %0d expected %0d", b_cyc[8], 7 * ST + 3); end
        n_cmp++;
        if (b_cyc[10] !== 7 * ST + 9) begin n_bad++; $display("FAIL b2b_third: got %0d expected %0d", b_cyc[10], 7 * ST + 9); end
    endtask

    task automatic test_rready_stall;
        int w, e, k, it;
        int pat [6] = '{1, 0, 0, 1, 1, 1};
        bus.rready = 1'b0;
        send_ar(4'd4, 32'h0, 4'd3, 3'b010, 2'b01, w);
        for (int t = 0; t < 20 && !bus.rvalid; t++) @(negedge clk);
        n_cmp++;
        if (bus.rvalid !== 1'b1) begin n_bad++; $display("FAIL stall_first_valid: got %b expected 1", bus.rvalid); end
        e = 0; k = 0; it = 0;
        while (e < 4 && it < 40) begin
            if (bus.rvalid) begin
                n_cmp++;
                if ({bus.rid, bus.rdata, bus.rlast} !== {4'd4, 32'h1000_0000 + 32'(e), e == 3}) begin
                    n_bad++;
                    $display("FAIL stall_hold[%0d]: got id=%h data=%h last=%b expected id=4 data=%h last=%b",
                             it, bus.rid, bus.rdata, bus.rlast, 32'h1000_0000 + 32'(e), e == 3);
                end
                bus.rready = (k < 6) ? pat[k][0] : 1'b1;
                k++;
                if (bus.rready) e++;
            end
            @(negedge clk);
            it++;
        end
        n_cmp++;
        if ({e, k} !== {32'd4, 32'd6}) begin n_bad++; $display("FAIL stall_count: got beats=%0d valid_cycles=%0d expected 4,6", e, k); end
        n_cmp++;
        if (bus.rvalid !== 1'b0) begin n_bad++; $display("FAIL stall_after_last: got rvalid=%b expected 0", bus.rvalid); end
        bus.rready = 1'b1;
    endtask

    task automatic test_err_fixed;
        int w;
        logic [2:0]  sz [3] = '{3'b001, 3'b010, 3'b010};
        logic [1:0]  bt [3] = '{2'b01, 2'b10, 2'b00};
        logic [31:0] ad [3] = '{32'h0, 32'h0, 32'h8};
        logic [31:0] ed [3] = '{32'h0, 32'h0, 32'h1000_0002};
        logic [1:0]  er [3] = '{2'b10, 2'b10, 2'b00};
        for (int i = 0; i < 3; i++) begin
            send_ar(4'(8 + i), ad[i], 4'd3, sz[i], bt[i], w);
            collect(4, 40);
            n_cmp++;
            if (nb !== 4) begin n_bad++; $display("FAIL errfix_nbeats[%0d]: got %0d expected 4", i, nb); end
            for (int k = 0; k < nb; k++) begin
                n_cmp++;
                if ({b_data[k], b_resp[k], b_last[k], b_id[k]} !== {ed[i], er[i], k == 3, 4'(8 + i)}) begin
                    n_bad++;
                    $display("FAIL errfix_beat[%0d][%0d]: got data=%h resp=%b last=%b id=%h expected data=%h resp=%b last=%b id=%h",
                             i, k, b_data[k], b_resp[k], b_last[k], b_id[k], ed[i], er[i], k == 3, 4'(8 + i));
                end
            end
        end
    endtask

    task automatic test_wrap_backdoor;
        int w;
        logic [31:0] ed [4] = '{32'hCAFE_03FE, 32'hCAFE_03FF, 32'h1000_0000, 32'hBEEF_0001};
        bus.rready = 1'b0;
        send_ar(4'd10, 32'h8000_0FFB, 4'd3, 3'b010, 2'b01, w);
        for (int t = 0; t < 20 && !bus.rvalid; t++) @(negedge clk);
        bd_write(1, 32'hBEEF_0001);
        bus.rready = 1'b1;
        collect(4, 40);
        n_cmp++;
        if (nb !== 4) begin n_bad++; $display("FAIL wrap_nbeats: got %0d expected 4", nb); end
        for (int k = 0; k < nb; k++) begin
            n_cmp++;
            if ({b_data[k], b_resp[k], b_last[k]} !== {ed[k], 2'b00, k == 3}) begin
                n_bad++;
                $display("FAIL wrap_beat[%0d]: got data=%h resp=%b last=%b expected data=%h resp=00 last=%b",
                         k, b_data[k], b_resp[k], b_last[k], ed[k], k == 3);
            end
        end
        bd_write(1, 32'h1000_0001);
    endtask

    task automatic test_reset_mid_burst;
        int w, hs, it, stray;
        send_ar(4'd7, 32'h0, 4'd7, 3'b010, 2'b01, w);
        hs = 0; it = 0;
        while (it < 40 && !(bus.rvalid && hs == 3)) begin
            if (bus.rvalid && bus.rready) hs++;
            @(negedge clk);
            it++;
        end
        n_cmp++;
        if ({bus.rvalid, bus.rdata} !== {1'b1, 32'h1000_0003}) begin
            n_bad++;
            $display("FAIL rstmid_beat4: got valid=%b data=%h expected 1,10000003", bus.rvalid, bus.rdata);
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({bus.rvalid, bus.arready} !== 2'b00) begin
            n_bad++;
            $display("FAIL rstmid_outputs: got rvalid,arready=%b expected 00", {bus.rvalid, bus.arready});
        end
        rst = 1'b0;
        stray = 0;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            if (bus.rvalid) stray++;
        end
        n_cmp++;
        if (stray !== 0) begin n_bad++; $display("FAIL rstmid_dropped: got %0d valid cycles expected 0", stray); end
        n_cmp++;
        if (bus.arready !== 1'b1) begin n_bad++; $display("FAIL rstmid_arready: got %b expected 1", bus.arready); end
        send_ar(4'd9, 32'h10, 4'd1, 3'b010, 2'b01, w);
        collect(2, 30);
        n_cmp++;
        if (nb !== 2) begin n_bad++; $display("FAIL rstmid_new_nbeats: got %0d expected 2", nb); end
        for (int k = 0; k < nb; k++) begin
            n_cmp++;
            if ({b_id[k], b_data[k], b_last[k], b_cyc[k]} !== {4'd9, 32'h1000_0004 + 32'(k), k == 1, 2 + k * ST}) begin
                n_bad++;
                $display("FAIL rstmid_new[%0d]: got id=%h data=%h last=%b cyc=%0d expected id=9 data=%h last=%b cyc=%0d",
                         k, b_id[k], b_data[k], b_last[k], b_cyc[k], 32'h1000_0004 + 32'(k), k == 1, 2 + k * ST);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        mem_we = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        bus.arid = '0;
        bus.araddr = '0;
        bus.arlen = '0;
        bus.arsize = 3'b010;
        bus.arburst = 2'b01;
        bus.arvalid = 1'b0;
        bus.rready = 1'b1;
        repeat (3) @(negedge clk);
        test_reset;
        for (int i = 0; i < 16; i++) bd_write(i, 32'h1000_0000 + 32'(i));
        bd_write(1022, 32'hCAFE_03FE);
        bd_write(1023, 32'hCAFE_03FF);
        test_incr_burst;
        test_back_to_back;
        test_rready_stall;
        test_err_fixed;
        test_wrap_backdoor;
        test_reset_mid_burst;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
